// File: rtl/bch_chien_search_ctrl.sv
// rtl/bch_chien_search_ctrl.sv - Chien search sequencer for a GF(2^13) BCH decoder
//
// Steps T constant-multiplier lanes once per clock to evaluate sigma(alpha^-p)
// for p = 0..N-1 and reports every root position.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      single-cycle search request, accepted only while idle
//   i_sigma      sigma_j at bits [j*M +: M], sigma_0 at the LSBs
//   i_deg        degree of sigma reported by the solver
//   o_busy       high from LOAD through FINISH
//   o_err_valid  one-cycle pulse, o_err_pos holds a root position
//   o_err_pos    root position p
//   o_err_cnt    roots found in the current search, saturating at 15
//   o_done       one-cycle end-of-search pulse
//   o_fail       root count differs from i_deg, held until the next search

module bch_chien_search_ctrl #(
    parameter int T = 8,
    parameter int N = 8191,
    parameter int M = 13
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [(T+1)*M-1:0] i_sigma,
    input  logic [3:0]         i_deg,
    output logic               o_busy,
    output logic               o_err_valid,
    output logic [M-1:0]       o_err_pos,
    output logic [3:0]         o_err_cnt,
    output logic               o_done,
    output logic               o_fail
);

    // x^13 + x^4 + x^3 + x + 1, including the x^M term
    localparam logic [M:0]   PRIM     = (M+1)'(14'h201B);
    localparam logic [M-1:0] LAST_POS = M'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_FINISH
    } state_t;

    // Multiply by alpha: shift left and fold the overflow back through PRIM.
    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
        logic [M-1:0] res;
        res = {a[M-2:0], 1'b0};
        if (a[M-1]) begin
            res = res ^ PRIM[M-1:0];
        end
        return res;
    endfunction

    // General GF(2^M) multiply; with a constant operand it reduces to an XOR network.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        acc = '0;
        for (int i = M - 1; i >= 0; i--) begin
            acc = gf_xtime(acc);
            if (b[i]) begin
                acc = acc ^ a;
            end
        end
        return acc;
    endfunction

    // alpha^-e built by repeated division by alpha. Odd values are divisible
    // only after adding PRIM (whose constant term is 1), which also restores
    // the top bit from the x^M term.
    function automatic logic [M-1:0] alpha_inv_pow(input int e);
        logic [M-1:0] x;
        logic [M:0]   tmp;
        x = M'(1);
        for (int i = 0; i < e; i++) begin
            tmp = {1'b0, x} ^ (x[0] ? PRIM : '0);
            x   = tmp[M:1];
        end
        return x;
    endfunction

    state_t r_state;
    state_t w_next_state;

    logic [(T+1)*M-1:0] r_sigma;
    logic [3:0]         r_deg;
    logic [M-1:0]       r_s0;
    logic [M-1:0]       r_lane [1:T];
    logic [M-1:0]       w_lane_next [1:T];
    logic [M-1:0]       r_pos;
    logic               r_err_valid;
    logic [M-1:0]       r_err_pos;
    logic [3:0]         r_err_cnt;
    logic               r_fail;

    logic [M-1:0]       w_sum;
    logic               w_root;
    logic               w_last;
    logic [3:0]         w_cnt_next;

    // Lane j advances by alpha^-j per position, so after p steps it holds
    // sigma_j * alpha^(-j*p).
    for (genvar j = 1; j <= T; j++) begin : g_lane
        localparam logic [M-1:0] C_STEP = alpha_inv_pow(j);
        assign w_lane_next[j] = gf_mul(r_lane[j], C_STEP);
    end

    always_comb begin
        w_sum = r_s0;
        for (int j = 1; j <= T; j++) begin
            w_sum = w_sum ^ r_lane[j];
        end
    end

    assign w_root     = (r_state == S_EVAL) && (w_sum == '0);
    assign w_last     = (r_pos == LAST_POS);
    assign w_cnt_next = (w_root && (r_err_cnt != 4'hF)) ? r_err_cnt + 4'd1 : r_err_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next_state = S_LOAD;
            S_LOAD:   w_next_state = S_EVAL;
            S_EVAL:   if (w_last) w_next_state = S_FINISH;
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sigma     <= '0;
            r_deg       <= '0;
            r_s0        <= '0;
            r_pos       <= '0;
            r_err_valid <= 1'b0;
            r_err_pos   <= '0;
            r_err_cnt   <= '0;
            r_fail      <= 1'b0;
            for (int j = 1; j <= T; j++) begin
                r_lane[j] <= '0;
            end
        end else begin
            r_err_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sigma <= i_sigma;
                        r_deg   <= i_deg;
                    end
                end
                S_LOAD: begin
                    r_s0      <= r_sigma[M-1:0];
                    r_pos     <= '0;
                    r_err_cnt <= '0;
                    r_fail    <= 1'b0;
                    for (int j = 1; j <= T; j++) begin
                        r_lane[j] <= r_sigma[j*M +: M];
                    end
                end
                S_EVAL: begin
                    for (int j = 1; j <= T; j++) begin
                        r_lane[j] <= w_lane_next[j];
                    end
                    if (!w_last) begin
                        r_pos <= r_pos + 1'b1;
                    end
                    r_err_valid <= w_root;
                    if (w_root) begin
                        r_err_pos <= r_pos;
                    end
                    r_err_cnt <= w_cnt_next;
                    // Uses the updated count so a root at the last position is included.
                    if (w_last) begin
                        r_fail <= (w_cnt_next != r_deg);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_FINISH);
    assign o_err_valid = r_err_valid;
    assign o_err_pos   = r_err_pos;
    assign o_err_cnt   = r_err_cnt;
    assign o_fail      = r_fail;

endmodule

// File: tb/tb_bch_chien_search_ctrl.sv
// tb/tb_bch_chien_search_ctrl.sv - self-checking bench for bch_chien_search_ctrl
module tb_bch_chien_search_ctrl;

    localparam int T  = 8;
    localparam int M  = 13;
    localparam int W  = (T + 1) * M;
    localparam int NA = 8191;
    localparam int NB = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sel;
    logic [W-1:0] sigma;
    logic [3:0]   deg;
    logic         start_a, start_b;

    logic         busy_a, valid_a, done_a, fail_a;
    logic [M-1:0] pos_a;
    logic [3:0]   cnt_a;
    logic         busy_b, valid_b, done_b, fail_b;
    logic [M-1:0] pos_b;
    logic [3:0]   cnt_b;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    bch_chien_search_ctrl #(.T(T), .N(NA), .M(M)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_sigma(sigma), .i_deg(deg),
        .o_busy(busy_a), .o_err_valid(valid_a), .o_err_pos(pos_a),
        .o_err_cnt(cnt_a), .o_done(done_a), .o_fail(fail_a)
    );

    bch_chien_search_ctrl #(.T(T), .N(NB), .M(M)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_sigma(sigma), .i_deg(deg),
        .o_busy(busy_b), .o_err_valid(valid_b), .o_err_pos(pos_b),
        .o_err_cnt(cnt_b), .o_done(done_b), .o_fail(fail_b)
    );

    int tests = 0;
    int fails = 0;

    int exp_t [0:8190];
    int log_t [0:8191];
    bit root_at [0:8190];
    int dut_pos_q [$];
    int prev_cnt [2];
    bit prev_fail [2];
    int model_cnt;
    bit model_fail;

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 8191];
    endfunction

    // sigma(alpha^-p) evaluated directly from log/antilog tables
    function automatic int geval(input logic [W-1:0] sg, input int p);
        int acc;
        acc = 0;
        for (int j = 0; j <= T; j++) begin
            acc = acc ^ gmul(int'(sg[j*M +: M]), exp_t[(8191 - (p * j) % 8191) % 8191]);
        end
        return acc;
    endfunction

    // {busy, err_valid, done, fail, err_cnt, err_pos}
    function automatic logic [20:0] outv(input bit b);
        if (b) return {busy_b, valid_b, done_b, fail_b, cnt_b, pos_b};
        return {busy_a, valid_a, done_a, fail_a, cnt_a, pos_a};
    endfunction

    function automatic logic [20:0] mask_pos(input logic [20:0] v);
        if (v[19]) return v;
        return {v[20:13], 13'd0};
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_sigma(input int nroots, output logic [W-1:0] sg);
        int c [0:T];
        bit used [0:NB-1];
        int r;
        for (int j = 0; j <= T; j++) c[j] = 0;
        for (int i = 0; i < NB; i++) used[i] = 1'b0;
        c[0] = 1;
        for (int k = 0; k < nroots; k++) begin
            do r = int'($urandom_range(0, NB - 1)); while (used[r]);
            used[r] = 1'b1;
            for (int j = k + 1; j >= 1; j--) c[j] = c[j] ^ gmul(c[j-1], exp_t[r]);
        end
        sg = '0;
        for (int j = 0; j <= T; j++) sg[j*M +: M] = M'(c[j]);
    endtask

    task automatic run_search(input logic [W-1:0] sg, input logic [3:0] dg, input bit b,
                              input int xstart_k, input int rst_k, input string name);
        int n;
        int total;
        int cum;
        int e_cnt;
        bit e_fail;
        bit ev;
        logic [20:0] a;
        logic [20:0] e;
        n = b ? NB : NA;
        total = 0;
        for (int p = 0; p < n; p++) begin
            root_at[p] = (geval(sg, p) == 0);
            if (root_at[p]) total++;
        end
        model_cnt  = (total > 15) ? 15 : total;
        model_fail = (model_cnt != int'(dg));
        dut_pos_q.delete();
        sel   = b;
        sigma = sg;
        deg   = dg;
        start = 1'b1;
        cum   = 0;
        for (int k = 1; k <= n + 4; k++) begin
            @(negedge clk);
            sigma = W'({$urandom(), $urandom(), $urandom(), $urandom()});
            deg   = 4'($urandom());
            start = (k == xstart_k);
            if (k == rst_k) begin
                start = 1'b0;
                rst   = 1'b1;
                #1;
                check({name, "_rst_async"}, outv(b), 21'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check({name, "_rst_idle"}, outv(b), 21'd0);
                end
                prev_cnt[0] = 0;  prev_cnt[1] = 0;
                prev_fail[0] = 0; prev_fail[1] = 0;
                return;
            end
            ev = (k >= 3 && k <= n + 2) ? root_at[k-3] : 1'b0;
            if (ev && cum < 15) cum++;
            e_cnt  = (k == 1) ? prev_cnt[b] : cum;
            e_fail = (k == 1) ? prev_fail[b] : ((k >= n + 2) ? model_fail : 1'b0);
            e = {(k <= n + 2), ev, (k == n + 2), e_fail, 4'(e_cnt), ev ? 13'(k - 3) : 13'd0};
            a = outv(b);
            if (a[19]) dut_pos_q.push_back(int'(a[12:0]));
            check(name, mask_pos(a), e);
        end
        start = 1'b0;
        prev_cnt[b]  = model_cnt;
        prev_fail[b] = model_fail;
    endtask

    logic [W-1:0] sg;
    int           nr;

    initial begin
        exp_t[0] = 1;
        log_t[1] = 0;
        log_t[0] = 0;
        for (int i = 1; i < 8191; i++) begin
            int v;
            v = exp_t[i-1] << 1;
            if ((v & 'h2000) != 0) v = v ^ 'h201B;
            exp_t[i] = v;
            log_t[v] = i;
        end
        prev_cnt[0] = 0;  prev_cnt[1] = 0;
        prev_fail[0] = 0; prev_fail[1] = 0;

        check("model_alpha13", 21'(exp_t[13]), 21'h1B);
        check("model_alpha_order", 21'(gmul(exp_t[8190], 2)), 21'd1);

        rst = 1'b1; start = 1'b0; sel = 1'b0; sigma = '0; deg = '0;
        repeat (3) @(negedge clk);
        check("reset_a", outv(0), 21'd0);
        check("reset_b", outv(1), 21'd0);
        rst = 1'b0;
        @(negedge clk);

        sg = '0; sg[0 +: M] = 13'd1; sg[M +: M] = 13'd1;
        run_search(sg, 4'd1, 1'b0, -1, -1, "root0");
        check("root0_count", 21'(dut_pos_q.size()), 21'd1);
        if (dut_pos_q.size() > 0) check("root0_pos", 21'(dut_pos_q[0]), 21'd0);

        sg = '0; sg[0 +: M] = 13'd1; sg[M +: M] = M'(exp_t[5]);
        run_search(sg, 4'd1, 1'b0, 500, -1, "root5");
        check("root5_count", 21'(dut_pos_q.size()), 21'd1);
        if (dut_pos_q.size() > 0) check("root5_pos", 21'(dut_pos_q[0]), 21'd5);

        sg = '0; sg[0 +: M] = 13'd1;
        sg[M +: M]   = M'(exp_t[3] ^ exp_t[100]);
        sg[2*M +: M] = M'(exp_t[103]);
        run_search(sg, 4'd2, 1'b0, -1, -1, "two_err");
        check("two_err_count", 21'(dut_pos_q.size()), 21'd2);
        if (dut_pos_q.size() == 2) begin
            check("two_err_pos0", 21'(dut_pos_q[0]), 21'd3);
            check("two_err_pos1", 21'(dut_pos_q[1]), 21'd100);
        end

        run_search(sg, 4'd3, 1'b1, -1, -1, "two_err_deg3");
        check("two_err_deg3_fail", 21'(model_fail), 21'd1);

        sg = '0; sg[0 +: M] = 13'd1; sg[M +: M] = M'(exp_t[254]);
        run_search(sg, 4'd1, 1'b1, NB + 2, -1, "last_pos");
        if (dut_pos_q.size() > 0) check("last_pos_val", 21'(dut_pos_q[0]), 21'd254);

        build_sigma(3, sg);
        run_search(sg, 4'd3, 1'b1, 40, 100, "mid_rst");

        sg = '0; sg[0 +: M] = 13'd1;
        run_search(sg, 4'd0, 1'b1, -1, -1, "no_roots");
        check("no_roots_cnt", 21'(model_cnt), 21'd0);

        sg = '0;
        run_search(sg, 4'd0, 1'b1, -1, -1, "all_zero");
        check("all_zero_cnt", 21'(model_cnt), 21'd15);
        check("all_zero_fail", 21'(model_fail), 21'd1);

        for (int i = 0; i < 8; i++) begin
            nr = int'($urandom_range(0, T));
            build_sigma(nr, sg);
            run_search(sg, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(nr),
                       1'b1, int'($urandom_range(1, NB + 3)), -1, "random");
        end

        sg = W'({$urandom(), $urandom(), $urandom(), $urandom()});
        run_search(sg, 4'($urandom_range(0, 8)), 1'b1, -1, -1, "random_sigma");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bch_chien_search_ctrl.md
Name: bch_chien_search_ctrl

Overview:
Sequencer for the Chien search stage of the BCH decoder over GF(2^13). It takes the error-locator polynomial sigma(x) from the Euclidean solver and steps a bank of T constant GF(2^13) multipliers once per clock. It reports every codeword position p where sigma(alpha^-p) = 0, then returns a completion status to the decoder top-level.

Parameters:
T, 8, maximum correctable errors (degree of sigma); number of constant-multiplier lanes
N, 8191, codeword length in positions scanned (shortened codes: N < 8191); range 1..8191
M, 13, field width (fixed; GF(2^13), primitive polynomial x^13+x^4+x^3+x+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request; accepted only when busy=0
sigma  in  (T+1)*M  coefficients; sigma_j at bits [j*M +: M]; sigma_0 at LSBs
deg  in  4  degree of sigma reported by the solver (0..T)
busy  out  1  high from the cycle after an accepted start until done
err_valid  out  1  one-cycle pulse: err_pos is a root position
err_pos  out  13  position p (0..N-1) of the detected error
err_cnt  out  4  running count of roots found in the current search (saturates at 15)
done  out  1  one-cycle pulse at end of search
fail  out  1  valid with done, held until next start: err_cnt != deg

Behaviour:
- Reset: state=IDLE. busy, err_valid, done, fail = 0. err_pos, err_cnt = 0. All lane registers = 0.
- States: IDLE -> LOAD -> EVAL -> FINISH -> IDLE.
- IDLE:
  - start=1 captures sigma and deg into registers, moves to LOAD next cycle and sets busy=1.
  - start while busy=1 is ignored; no queuing.
- LOAD (1 cycle):
  - Lane registers r_j <= sigma_j for j=1..T; s0 <= sigma_0.
  - Position counter p <= 0; err_cnt <= 0; fail <= 0.
- EVAL (exactly N cycles, p = 0..N-1):
  - Combinational sum S = s0 XOR r_1 XOR ... XOR r_T, i.e. sigma(alpha^-p).
  - Each cycle, r_j <= r_j * alpha^(8191-j mod 8191) using a constant GF(2^13) multiplier per lane. Multiplier constants are generated from M and the primitive polynomial, not hand-entered.
  - If S == 0: next cycle err_valid=1, err_pos=p, and err_cnt increments (saturating at 15). Output latency is 1 clock from evaluation.
  - p wraps never. When p == N-1, transition to FINISH.
- FINISH (1 cycle):
  - done=1 for one cycle.
  - fail = (err_cnt_final != deg); it must include an err_valid asserted in this same cycle for p=N-1.
  - busy=0 in the cycle after done.
  - err_cnt and fail hold until the next LOAD.
- Whole search latency: start -> done = N+2 cycles.
- Boundary cases:
  - sigma all zero: S==0 every cycle, giving N pulses. err_cnt saturates at 15 and fail=1 unless deg is 15 (out of range, so fail=1 in practice).
  - deg=0 with sigma_0 != 0: no roots, fail=0.
  - Root at p=0: err_valid appears in the first EVAL+1 cycle.
  - Root at p=N-1: err_valid coincides with done.
  - Asynchronous rst at any point returns to IDLE with all outputs cleared. A partial search is discarded and no done is emitted.
  - start asserted in the same cycle as done is ignored, because busy is still 1.
- The sigma and deg inputs may change after acceptance without effect.

Test Plan:
- Root at 0: sigma=1+x (sigma_0=1, sigma_1=1, rest 0), deg=1, N=8191 -> single err_valid with err_pos=0 one cycle after first EVAL; done at start+8193; err_cnt=1; fail=0.
- Root at 5: sigma=1+alpha^5 x, deg=1 -> err_pos=5 only; err_cnt=1; fail=0.
- Two errors: sigma=(1+alpha^3 x)(1+alpha^100 x) expanded, deg=2 -> err_pos 3 then 100; err_cnt=2; fail=0. Run again with deg=3 -> fail=1.
- Last position with N=255: sigma=1+alpha^254 x, deg=1 -> err_valid at p=254 in the same cycle as done; fail=0.
- Busy/reset: second start during EVAL -> ignored and search unchanged. Assert rst mid-EVAL -> busy=0, no done, err_cnt=0. A new start then runs a clean search.
- No roots: sigma=1, deg=0 -> zero err_valid, done after N+2 cycles, fail=0. Repeat with sigma all zero -> err_cnt=15, fail=1.
